// File: rtl/muldiv_if.sv
// Request/response bundle for muldiv_unit: one request handshake, one result handshake, plus flush and busy.
interface muldiv_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: shift-add multiplier (MUL_STEP bits/cycle) and radix-2 restoring divider.
module muldiv_unit #(
  parameter int XLEN     = 64,
  parameter int MUL_STEP = 2
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave io
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] MUL_IT_X = CW'(XLEN / MUL_STEP);
  localparam logic [CW-1:0] MUL_IT_W = CW'(32 / MUL_STEP);
  localparam logic [CW-1:0] DIV_IT_X = CW'(XLEN);
  localparam logic [CW-1:0] DIV_IT_W = CW'(32);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [3:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;

  logic              word_in;
  logic [2:0]        f3_in;
  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_ext;
  logic              b_zero, div_ovf, illegal;
  logic [2*XLEN-1:0] prod_nx, p_fin;
  logic [XLEN:0]     r_sh, r_diff;
  logic [XLEN-1:0]   quo_nx, rem_nx, q_fin, r_fin;
  logic [CW-1:0]     mul_it, div_it;

  function automatic logic [XLEN-1:0] sext_w(input logic [31:0] x);
    logic signed [31:0]   xs;
    logic signed [XLEN-1:0] xl;
    xs = x;
    xl = xs;
    return xl;
  endfunction

  function automatic logic [XLEN-1:0] fit_w(input logic word, input logic [XLEN-1:0] x);
    return word ? sext_w(x[31:0]) : x;
  endfunction

  function automatic logic [XLEN-1:0] cneg_x(input logic en, input logic [XLEN-1:0] x);
    return en ? (~x + XLEN'(1)) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg_p(input logic en, input logic [2*XLEN-1:0] x);
    return en ? (~x + (2*XLEN)'(1)) : x;
  endfunction

  // Operand conditioning: width select, extension, and magnitude/sign split.
  always_comb begin
    word_in = io.op[3];
    f3_in   = io.op[2:0];
    a_sgn   = (f3_in == 3'b001) || (f3_in == 3'b010) || (f3_in == 3'b100) || (f3_in == 3'b110);
    b_sgn   = (f3_in == 3'b001) || (f3_in == 3'b100) || (f3_in == 3'b110);
    a_ext   = word_in ? (a_sgn ? sext_w(io.a[31:0]) : XLEN'(io.a[31:0])) : io.a;
    b_ext   = word_in ? (b_sgn ? sext_w(io.b[31:0]) : XLEN'(io.b[31:0])) : io.b;
    a_neg   = a_sgn & a_ext[XLEN-1];
    b_neg   = b_sgn & b_ext[XLEN-1];
    a_mag   = cneg_x(a_neg, a_ext);
    b_mag   = cneg_x(b_neg, b_ext);
    min_ext = word_in ? sext_w(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    b_zero  = (b_ext == '0);
    div_ovf = f3_in[2] && a_sgn && b_sgn && (a_ext == min_ext) && (&b_ext);
    illegal = word_in && (f3_in inside {3'b001, 3'b010, 3'b011});
  end

  // One iteration of each datapath plus the sign-corrected final values.
  always_comb begin
    prod_nx = prod_q;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) prod_nx = prod_nx + (mcand_q << i);
    end
    p_fin  = cneg_p(neg_q, prod_nx);
    r_sh   = {rem_q, quo_q[XLEN-1]};
    r_diff = r_sh - {1'b0, dvs_q};
    rem_nx = r_diff[XLEN] ? r_sh[XLEN-1:0] : r_diff[XLEN-1:0];
    quo_nx = {quo_q[XLEN-2:0], ~r_diff[XLEN]};
    q_fin  = cneg_x(neg_q, quo_nx);
    r_fin  = cneg_x(rneg_q, rem_nx);
    mul_it = op_q[3] ? MUL_IT_W : MUL_IT_X;
    div_it = op_q[3] ? DIV_IT_W : DIV_IT_X;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid && !io.flush) begin
          op_d   = io.op;
          cnt_d  = '0;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (illegal) begin
            result_d = '0;
            state_d  = DONE;
          end else if (!f3_in[2]) begin
            prod_d   = '0;
            mcand_d  = {{XLEN{1'b0}}, a_mag};
            mplier_d = b_mag;
            state_d  = MUL;
          end else if (b_zero) begin
            result_d = fit_w(word_in, f3_in[1] ? a_ext : {XLEN{1'b1}});
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = fit_w(word_in, f3_in[1] ? {XLEN{1'b0}} : a_ext);
            state_d  = DONE;
          end else begin
            // Left-align word dividends so the MSB always leaves from bit XLEN-1.
            quo_d   = word_in ? (a_mag << (XLEN - 32)) : a_mag;
            rem_d   = '0;
            dvs_d   = b_mag;
            state_d = DIV;
          end
        end
      end
      MUL: begin
        prod_d   = prod_nx;
        mcand_d  = mcand_q << MUL_STEP;
        mplier_d = mplier_q >> MUL_STEP;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == mul_it - CW'(1)) begin
          result_d = (op_q[2:0] == 3'b000) ? fit_w(op_q[3], p_fin[XLEN-1:0])
                                           : p_fin[2*XLEN-1:XLEN];
          state_d  = DONE;
        end
      end
      DIV: begin
        quo_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == div_it - CW'(1)) begin
          result_d = fit_w(op_q[3], op_q[1] ? r_fin : q_fin);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (io.flush) state_d = IDLE;
  end

  // Control state: synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Datapath registers: no reset, only meaningful while an operation is live.
  always_ff @(posedge clk) begin
    op_q     <= op_d;
    neg_q    <= neg_d;
    rneg_q   <= rneg_d;
    prod_q   <= prod_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    quo_q    <= quo_d;
    rem_q    <= rem_d;
    dvs_q    <= dvs_d;
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.busy      = (state_q != IDLE);
  assign io.result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit (XLEN=64, MUL_STEP=2) plus handshake/flush/reset sequences.
module tb_muldiv_unit;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN)) bus ();
  muldiv_unit #(.XLEN(XLEN), .MUL_STEP(2)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Drive one request, scramble inputs after the accept edge, count cycles to out_valid.
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op = ~op;
    bus.a  = ~a;
    bus.b  = b ^ 64'h5A5A_0000_0000_00F3;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.result;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    int          lat;
    int          seen;

    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = '0;
    bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;

    vecs[0]  = '{4'h0, 64'h3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 33};
    vecs[1]  = '{4'h1, '1, '1, 64'h0, 33};
    vecs[2]  = '{4'h3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[3]  = '{4'h2, '1, 64'h2, '1, 33};
    vecs[4]  = '{4'h4, 64'h7, 64'h0, '1, 1};
    vecs[5]  = '{4'h6, 64'h7, 64'h0, 64'h7, 1};
    vecs[6]  = '{4'hD, 64'h5, 64'h0, '1, 1};
    vecs[7]  = '{4'h4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
    vecs[8]  = '{4'h6, 64'h8000_0000_0000_0000, '1, 64'h0, 1};
    vecs[9]  = '{4'hC, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[10] = '{4'hE, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, '1, 33};
    vecs[11] = '{4'h8, 64'hDEAD_BEEF_4000_0000, 64'h1234_5678_0000_0002, 64'hFFFF_FFFF_8000_0000, 17};
    vecs[12] = '{4'h4, 64'hFFFF_FFFF_FFFF_FF9C, 64'h7, 64'hFFFF_FFFF_FFFF_FFF2, 65};
    vecs[13] = '{4'h6, 64'hFFFF_FFFF_FFFF_FF9C, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[14] = '{4'h5, 64'd100, 64'd7, 64'd14, 65};
    vecs[15] = '{4'h7, '1, 64'd10, 64'd5, 65};
    vecs[16] = '{4'hD, 64'h0000_0000_FFFF_FFFF, 64'h1, '1, 33};
    vecs[17] = '{4'h0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h5, 64'hFFFF_FFFF_FFFF_FFF1, 33};
    vecs[18] = '{4'h1, 64'h8000_0000_0000_0000, 64'h2, '1, 33};
    vecs[19] = '{4'h9, 64'h5, 64'h6, 64'h0, 1};
    vecs[20] = '{4'h4, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[21] = '{4'h6, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 65};
    vecs[22] = '{4'hF, 64'h0000_0001_8000_0005, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0005, 1};
    vecs[23] = '{4'hF, 64'hFFFF_FFFF_8000_0005, 64'h10, 64'h5, 33};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst result", bus.result, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 24; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d result", i), res, vecs[i].exp);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      release_result();
    end

    // Back-pressure: result held through five stalled cycles, then handshake frees the unit
    issue(4'h5, 64'd100, 64'd7, res, lat);
    check("bp first result", res, 64'd14);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp%0d out_valid", k), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp%0d result", k), bus.result, 64'd14);
      check($sformatf("bp%0d in_ready", k), 64'(bus.in_ready), 64'd0);
    end
    release_result();
    check("bp release in_ready", 64'(bus.in_ready), 64'd1);
    check("bp release out_valid", 64'(bus.out_valid), 64'd0);
    issue(4'h0, 64'd6, 64'd7, res, lat);
    check("bp next result", res, 64'd42);
    check("bp next latency", 64'(lat), 64'd33);
    release_result();

    // Flush ten cycles into a 64-bit divide
    bus.in_valid = 1'b1; bus.op = 4'h4; bus.a = 64'd1000; bus.b = 64'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("flush pre busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush in_ready", 64'(bus.in_ready), 64'd1);
    check("flush out_valid", 64'(bus.out_valid), 64'd0);
    check("flush busy", 64'(bus.busy), 64'd0);
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("flush no out_valid", 64'(seen), 64'd0);
    issue(4'h6, 64'd1000, 64'd3, res, lat);
    check("after flush result", res, 64'd1);
    check("after flush latency", 64'(lat), 64'd65);

    // Flush together with out_ready drops the result
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    check("flush+ready out_valid", 64'(bus.out_valid), 64'd0);
    check("flush+ready in_ready", 64'(bus.in_ready), 64'd1);

    // Request presented together with flush is not accepted
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.op = 4'h0; bus.a = 64'd2; bus.b = 64'd2;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("flush blocks accept", 64'(bus.busy), 64'd0);

    // Reset pulsed mid-multiply
    bus.in_valid = 1'b1; bus.op = 4'h0; bus.a = 64'd9; bus.b = 64'd9;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid-rst out_valid", 64'(bus.out_valid), 64'd0);
    check("mid-rst result", bus.result, 64'd0);
    check("mid-rst busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid-rst in_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("mid-rst no out_valid", 64'(seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 64, operand/result width; SHALL be 32 or 64.
REQ-002 Parameter MUL_STEP, default 2, multiplier bits retired per cycle; SHALL be 1, 2 or 4.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  pipeline kill; discards any accepted or in-flight operation.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  unit can accept a request.
REQ-008 op  input  4  op[3] = word, op[2:0] = RISC-V M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-009 a, b  input  XLEN each  source operands rs1, rs2.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  XLEN  result of the operation.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV and DONE; in_ready SHALL be high only in IDLE.
REQ-015 Accept SHALL occur when in_valid & in_ready & ~flush; the unit SHALL capture op, a and b, and later changes to these inputs SHALL NOT affect the result.
REQ-016 Word ops SHALL use a[31:0] and b[31:0], sign-extended for signed ops and zero-extended otherwise, with an effective width W = 32; all other ops SHALL use W = XLEN.
REQ-017 Signed ops SHALL operate on operand magnitudes and apply sign correction in DONE: MULH signs both operands, MULHSU signs a only, MULHU signs neither.
REQ-018 MUL SHALL iterate ceil(2W/2)/MUL_STEP = W/MUL_STEP cycles using shift-add over a 2W-bit product.
REQ-019 DIV SHALL iterate W cycles using radix-2 restoring division, producing a W-bit quotient and remainder.
REQ-020 Latency, from the accept edge to out_valid rising, SHALL be iterations + 1. For XLEN=64 and MUL_STEP=2 this gives: MUL/MULH/MULHSU/MULHU 33 cycles, MULW 17, 64-bit divide/remainder 65, word divide/remainder 33.
REQ-021 Divide by zero SHALL bypass iteration (IDLE->DONE, latency 1): quotient = all ones (W bits), remainder = dividend.
REQ-022 Signed overflow (dividend = -2^(W-1), divisor = -1) SHALL bypass iteration (latency 1): quotient = dividend, remainder = 0.
REQ-023 The quotient SHALL be negated when the operand signs differ and the divisor is nonzero; the remainder SHALL take the sign of the dividend.
REQ-024 Results of MUL and MULW SHALL be the low W bits of the product; MULH, MULHSU and MULHU SHALL return the high XLEN bits.
REQ-025 Every word-op result, including DIVUW and REMUW, SHALL be sign-extended from bit 31.
REQ-026 op[3]=1 with op[2:0] in 001..011 is illegal; it SHALL complete with latency 1 and result 0.
REQ-027 In DONE, out_valid SHALL be 1; result SHALL be held stable while out_ready is 0; on out_ready the FSM SHALL go to IDLE, so in_ready rises the next cycle and there is no same-cycle reaccept.
REQ-028 Flush in any state SHALL force IDLE on the next edge, with out_valid 0 on that edge and no result delivered.
REQ-029 Flush and out_ready in the same cycle SHALL be treated as a flush, and the result is dropped.
REQ-030 The iteration counter SHALL be log2(XLEN)+1 bits wide and SHALL NOT wrap; it terminates exactly at the iteration count.

Reset
REQ-031 When rst_n=0 at a clock edge: state = IDLE, out_valid = 0, result = 0, counter = 0, busy = 0; in_ready = 1 in the cycle after reset is released.
REQ-032 Reset mid-operation SHALL abandon the operation with no out_valid pulse.

Verification
REQ-033 MUL a=3, b=0xFFFF_FFFF_FFFF_FFFE -> result 0xFFFF_FFFF_FFFF_FFFA, out_valid exactly 33 cycles after accept.
REQ-034 a=b=all ones: MULH -> 0, MULHU -> 0xFFFF_FFFF_FFFF_FFFE; MULHSU with a=all ones, b=2 -> all ones.
REQ-035 DIV a=7, b=0 -> all ones, latency 1; REM a=7, b=0 -> 7; DIVUW a=5, b=0 -> all ones.
REQ-036 DIV a=0x8000_0000_0000_0000, b=all ones -> 0x8000_0000_0000_0000 and REM -> 0; DIVW a=0x8000_0000, b=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000; REMW a=-7, b=2 -> all ones (-1).
REQ-037 Back-pressure: out_ready held low for 5 cycles in DONE -> result and out_valid stable, in_ready 0; out_ready=1 -> in_ready=1 next cycle and a new request is accepted.
REQ-038 Flush 10 cycles into a DIV -> out_valid never asserts, in_ready=1 next cycle; rst_n pulsed low mid-MUL -> same behaviour, with outputs at REQ-031 values.
